// File: rtl/pc_gen_pkg.sv
// Shared types and constants for the program-counter generator.
package pc_gen_pkg;

    typedef enum logic [1:0] {
        BOOT = 2'd0,
        RUN  = 2'd1,
        HALT = 2'd2
    } state_t;

    localparam int unsigned PC_INC     = 4;
    localparam logic [1:0]  ALIGN_MASK = 2'b11;

endpackage

// File: rtl/pc_next_sel.sv
// Next-PC priority mux (restart > redirect > accepted fetch > hold) with XLEN+1 limit compare.
// Optional PC_GEN_ALIGN_CHECK_EN: misaligned redirects are replaced by TRAP_VECTOR.
module pc_next_sel
    import pc_gen_pkg::*;
#(
    parameter int              XLEN         = 32,
    parameter logic [XLEN-1:0] RESET_VECTOR = 32'h0000_0000,
    parameter logic [XLEN-1:0] PC_LIMIT     = 32'h0000_0024,
    parameter logic [XLEN-1:0] TRAP_VECTOR  = 32'h0000_0100
) (
    input  logic            restart,
    input  logic            run,
    input  logic            redirect_valid,
    input  logic [XLEN-1:0] redirect_pc,
    input  logic            fetch_ready,
    input  logic [XLEN-1:0] fetch_pc,
    output logic [XLEN-1:0] next_pc,
    output logic            to_boot,
    output logic            to_halt,
    output logic            misalign
);

    localparam int CW = XLEN + 1;

    logic [CW-1:0] cand;
    logic          limit_chk;

    always_comb begin
        cand      = {1'b0, fetch_pc};
        limit_chk = 1'b0;
        next_pc   = fetch_pc;
        to_boot   = 1'b0;
        to_halt   = 1'b0;
        misalign  = 1'b0;

        if (restart) begin
            next_pc = RESET_VECTOR;
            to_boot = 1'b1;
        end else if (run) begin
            if (redirect_valid) begin
                limit_chk = 1'b1;
`ifdef PC_GEN_ALIGN_CHECK_EN
                if ((redirect_pc[1:0] & ALIGN_MASK) != 2'b00) begin
                    cand     = {1'b0, TRAP_VECTOR};
                    misalign = 1'b1;
                end else begin
                    cand = {1'b0, redirect_pc};
                end
`else
                cand = {1'b0, redirect_pc[XLEN-1:2], redirect_pc[1:0] & ~ALIGN_MASK};
`endif
            end else if (fetch_ready) begin
                // Carry into bit XLEN lands above any limit, so the PC never wraps.
                cand      = {1'b0, fetch_pc} + CW'(PC_INC);
                limit_chk = 1'b1;
            end

            if (limit_chk) begin
                if (cand >= {1'b0, PC_LIMIT}) begin
                    next_pc = PC_LIMIT;
                    to_halt = 1'b1;
                end else begin
                    next_pc = cand[XLEN-1:0];
                end
            end
        end
    end

endmodule

// File: rtl/pc_gen.sv
// Fetch-address generator: BOOT/RUN/HALT FSM, registered outputs, valid/ready toward imem.
// PC_GEN_ALIGN_CHECK_EN enables trapping of misaligned redirects and the misalign_err pulse.
module pc_gen
    import pc_gen_pkg::*;
#(
    parameter int              XLEN         = 32,
    parameter logic [XLEN-1:0] RESET_VECTOR = 32'h0000_0000,
    parameter logic [XLEN-1:0] PC_LIMIT     = 32'h0000_0024,
    parameter logic [XLEN-1:0] TRAP_VECTOR  = 32'h0000_0100
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            restart,
    input  logic            redirect_valid,
    input  logic [XLEN-1:0] redirect_pc,
    output logic            fetch_valid,
    input  logic            fetch_ready,
    output logic [XLEN-1:0] fetch_pc,
    output logic            halted,
    output logic            misalign_err
);

    state_t          state_q, state_d;
    logic [XLEN-1:0] fetch_pc_q, fetch_pc_d;
    logic            fetch_valid_q, fetch_valid_d;
    logic            halted_q, halted_d;
    logic            misalign_q, misalign_d;

    logic [XLEN-1:0] sel_pc;
    logic            sel_boot;
    logic            sel_halt;
    logic            sel_misalign;

    pc_next_sel #(
        .XLEN         (XLEN),
        .RESET_VECTOR (RESET_VECTOR),
        .PC_LIMIT     (PC_LIMIT),
        .TRAP_VECTOR  (TRAP_VECTOR)
    ) u_next_sel (
        .restart        (restart),
        .run            (fetch_valid_q),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .fetch_ready    (fetch_ready),
        .fetch_pc       (fetch_pc_q),
        .next_pc        (sel_pc),
        .to_boot        (sel_boot),
        .to_halt        (sel_halt),
        .misalign       (sel_misalign)
    );

    always_comb begin
        state_d    = state_q;
        fetch_pc_d = sel_pc;
        misalign_d = sel_misalign;

        if (sel_boot) begin
            state_d = BOOT;
        end else begin
            case (state_q)
                BOOT:    state_d = RUN;
                RUN:     state_d = sel_halt ? HALT : RUN;
                HALT:    state_d = HALT;
                default: state_d = BOOT;
            endcase
        end

        // Output flags are decoded from the next state so they come straight off flops.
        fetch_valid_d = (state_d == RUN);
        halted_d      = (state_d == HALT);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= BOOT;
            fetch_pc_q    <= RESET_VECTOR;
            fetch_valid_q <= 1'b0;
            halted_q      <= 1'b0;
            misalign_q    <= 1'b0;
        end else begin
            state_q       <= state_d;
            fetch_pc_q    <= fetch_pc_d;
            fetch_valid_q <= fetch_valid_d;
            halted_q      <= halted_d;
            misalign_q    <= misalign_d;
        end
    end

    assign fetch_valid = fetch_valid_q;
    assign fetch_pc    = fetch_pc_q;
    assign halted      = halted_q;
`ifdef PC_GEN_ALIGN_CHECK_EN
    assign misalign_err = misalign_q;
`else
    assign misalign_err = 1'b0;
`endif

endmodule

// File: tb/tb_pc_gen.sv
// Bench for pc_gen: two instances (default limit and an all-ones limit) share stimulus
// and are compared against a per-instance address-stream model.
module tb_pc_gen;

    localparam int M_BOOT = 0;
    localparam int M_RUN  = 1;
    localparam int M_HALT = 2;
`ifdef PC_GEN_ALIGN_CHECK_EN
    localparam bit ALIGN_CHK = 1'b1;
`else
    localparam bit ALIGN_CHK = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst_n;
    logic        restart;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        fetch_ready;
    logic [1:0]  fv, hl, me;
    logic [31:0] fpc [2];

    int     checks = 0;
    int     errors = 0;
    int     m_mode [2];
    longint m_pc   [2];
    bit     m_err  [2];
    longint lim    [2];

    always #5 clk = ~clk;

    pc_gen dut_a (
        .clk(clk), .rst_n(rst_n), .restart(restart),
        .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
        .fetch_valid(fv[0]), .fetch_ready(fetch_ready), .fetch_pc(fpc[0]),
        .halted(hl[0]), .misalign_err(me[0])
    );

    pc_gen #(.PC_LIMIT(32'hFFFF_FFFF)) dut_b (
        .clk(clk), .rst_n(rst_n), .restart(restart),
        .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
        .fetch_valid(fv[1]), .fetch_ready(fetch_ready), .fetch_pc(fpc[1]),
        .halted(hl[1]), .misalign_err(me[1])
    );

    task automatic model_reset();
        for (int i = 0; i < 2; i++) begin
            m_mode[i] = M_BOOT;
            m_pc[i]   = 0;
            m_err[i]  = 1'b0;
        end
    endtask

    // One clock of the address stream, from the inputs presented at this edge.
    task automatic model_step(input int i);
        longint rp;
        longint cand;
        bit     chk;
        rp       = {32'd0, redirect_pc};
        cand     = m_pc[i];
        chk      = 1'b0;
        m_err[i] = 1'b0;
        if (restart) begin
            m_mode[i] = M_BOOT;
            m_pc[i]   = 0;
        end else if (m_mode[i] == M_BOOT) begin
            m_mode[i] = M_RUN;
        end else if (m_mode[i] == M_RUN) begin
            if (redirect_valid) begin
                chk = 1'b1;
                if (ALIGN_CHK && (rp % 4) != 0) begin
                    cand     = 256;
                    m_err[i] = 1'b1;
                end else begin
                    cand = rp - (rp % 4);
                end
            end else if (fetch_ready) begin
                chk  = 1'b1;
                cand = m_pc[i] + 4;
            end
            if (chk) begin
                if (cand >= lim[i]) begin
                    m_mode[i] = M_HALT;
                    m_pc[i]   = lim[i];
                end else begin
                    m_pc[i] = cand;
                end
            end
        end
    endtask

    task automatic step();
        model_step(0);
        model_step(1);
        @(posedge clk);
        #1;
    endtask

    task automatic do_restart();
        restart        = 1'b1;
        redirect_valid = 1'b0;
        step();
        restart = 1'b0;
        step();
    endtask

    task automatic test_reset();
        #2;
        for (int i = 0; i < 2; i++) begin
            checks++;
            if (fpc[i] !== 32'h0 || fv[i] !== 1'b0 || hl[i] !== 1'b0 || me[i] !== 1'b0) begin
                errors++;
                $display("FAIL reset[%0d]: pc=%h fv=%b hl=%b me=%b, required pc=0 fv=0 hl=0 me=0",
                         i, fpc[i], fv[i], hl[i], me[i]);
            end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic test_stream();
        fetch_ready = 1'b1;
        rst_n       = 1'b1;
        checks++;
        if (fv[0] !== 1'b0) begin
            errors++;
            $display("FAIL boot_cycle: fetch_valid=%b, required 0", fv[0]);
        end
        for (int k = 0; k <= 8; k++) begin
            step();
            checks++;
            if (fv[0] !== 1'b1 || fpc[0] !== 32'(4 * k)) begin
                errors++;
                $display("FAIL stream[%0d]: fv=%b pc=%h, required fv=1 pc=%h", k, fv[0], fpc[0], 4 * k);
            end
        end
        step();
        checks++;
        if (hl[0] !== 1'b1 || fv[0] !== 1'b0 || fpc[0] !== 32'h24) begin
            errors++;
            $display("FAIL stream_halt: hl=%b fv=%b pc=%h, required hl=1 fv=0 pc=24", hl[0], fv[0], fpc[0]);
        end
        checks++;
        if (fpc[1] !== m_pc[1][31:0] || fv[1] !== 1'b1) begin
            errors++;
            $display("FAIL stream_b: pc=%h fv=%b, required pc=%h fv=1", fpc[1], fv[1], m_pc[1][31:0]);
        end
    endtask

    task automatic test_stall();
        do_restart();
        fetch_ready = 1'b1;
        step();
        step();
        fetch_ready = 1'b0;
        for (int k = 0; k < 3; k++) begin
            step();
            checks++;
            if (fpc[0] !== 32'h8 || fv[0] !== 1'b1) begin
                errors++;
                $display("FAIL stall[%0d]: pc=%h fv=%b, required pc=8 fv=1", k, fpc[0], fv[0]);
            end
        end
        fetch_ready = 1'b1;
        step();
        checks++;
        if (fpc[0] !== 32'hC) begin
            errors++;
            $display("FAIL stall_release: pc=%h, required c", fpc[0]);
        end
    endtask

    task automatic test_redirect_stall();
        do_restart();
        fetch_ready = 1'b1;
        step();
        fetch_ready    = 1'b0;
        redirect_valid = 1'b1;
        redirect_pc    = 32'h10;
        step();
        checks++;
        if (fpc[0] !== 32'h10 || fv[0] !== 1'b1) begin
            errors++;
            $display("FAIL redirect_stall: pc=%h fv=%b, required pc=10 fv=1", fpc[0], fv[0]);
        end
        restart = 1'b1;
        step();
        checks++;
        if (fpc[0] !== 32'h0 || fv[0] !== 1'b0 || hl[0] !== 1'b0) begin
            errors++;
            $display("FAIL restart_over_redirect: pc=%h fv=%b hl=%b, required pc=0 fv=0 hl=0",
                     fpc[0], fv[0], hl[0]);
        end
        restart        = 1'b0;
        redirect_valid = 1'b0;
    endtask

    task automatic test_limit_redirect();
        do_restart();
        redirect_valid = 1'b1;
        redirect_pc    = 32'h30;
        step();
        checks++;
        if (hl[0] !== 1'b1 || fv[0] !== 1'b0 || fpc[0] !== 32'h24) begin
            errors++;
            $display("FAIL limit_redirect: hl=%b fv=%b pc=%h, required hl=1 fv=0 pc=24", hl[0], fv[0], fpc[0]);
        end
        checks++;
        if (fpc[1] !== 32'h30 || hl[1] !== 1'b0) begin
            errors++;
            $display("FAIL limit_redirect_b: pc=%h hl=%b, required pc=30 hl=0", fpc[1], hl[1]);
        end
        redirect_pc = 32'h8;
        fetch_ready = 1'b1;
        step();
        checks++;
        if (hl[0] !== 1'b1 || fpc[0] !== 32'h24) begin
            errors++;
            $display("FAIL halt_ignores_redirect: hl=%b pc=%h, required hl=1 pc=24", hl[0], fpc[0]);
        end
        redirect_valid = 1'b0;
        restart        = 1'b1;
        step();
        checks++;
        if (hl[0] !== 1'b0 || fv[0] !== 1'b0 || fpc[0] !== 32'h0) begin
            errors++;
            $display("FAIL halt_restart: hl=%b fv=%b pc=%h, required hl=0 fv=0 pc=0", hl[0], fv[0], fpc[0]);
        end
        restart = 1'b0;
        step();
        checks++;
        if (fv[0] !== 1'b1 || fpc[0] !== 32'h0) begin
            errors++;
            $display("FAIL restart_first_valid: fv=%b pc=%h, required fv=1 pc=0", fv[0], fpc[0]);
        end
    endtask

    task automatic test_wrap();
        do_restart();
        fetch_ready    = 1'b0;
        redirect_valid = 1'b1;
        redirect_pc    = 32'hFFFF_FFFC;
        step();
        checks++;
        if (fpc[1] !== 32'hFFFF_FFFC || fv[1] !== 1'b1) begin
            errors++;
            $display("FAIL wrap_setup: pc=%h fv=%b, required pc=fffffffc fv=1", fpc[1], fv[1]);
        end
        redirect_valid = 1'b0;
        fetch_ready    = 1'b1;
        step();
        checks++;
        if (hl[1] !== 1'b1 || fv[1] !== 1'b0 || fpc[1] !== 32'hFFFF_FFFF) begin
            errors++;
            $display("FAIL wrap_halt: hl=%b fv=%b pc=%h, required hl=1 fv=0 pc=ffffffff", hl[1], fv[1], fpc[1]);
        end
    endtask

    task automatic test_misalign();
        logic [31:0] exp_pc;
        logic        exp_me;
        exp_pc = ALIGN_CHK ? 32'h100 : 32'h10;
        exp_me = ALIGN_CHK;
        do_restart();
        fetch_ready    = 1'b0;
        redirect_valid = 1'b1;
        redirect_pc    = 32'h12;
        step();
        checks++;
        if (fpc[1] !== exp_pc || me[1] !== exp_me) begin
            errors++;
            $display("FAIL misalign: pc=%h me=%b, required pc=%h me=%b", fpc[1], me[1], exp_pc, exp_me);
        end
        checks++;
        if (fpc[0] !== m_pc[0][31:0] || me[0] !== m_err[0] || hl[0] !== (m_mode[0] == M_HALT)) begin
            errors++;
            $display("FAIL misalign_a: pc=%h me=%b hl=%b, required pc=%h me=%b hl=%b",
                     fpc[0], me[0], hl[0], m_pc[0][31:0], m_err[0], m_mode[0] == M_HALT);
        end
        redirect_valid = 1'b0;
        step();
        checks++;
        if (me[1] !== 1'b0 || me[0] !== 1'b0) begin
            errors++;
            $display("FAIL misalign_pulse: me=%b, required 00", me);
        end
    endtask

    task automatic test_random();
        do_restart();
        for (int n = 0; n < 500; n++) begin
            restart        = ($urandom_range(0, 19) == 0);
            redirect_valid = ($urandom_range(0, 3) == 0);
            redirect_pc    = ($urandom_range(0, 3) == 0) ? $urandom : 32'($urandom_range(0, 'h40));
            fetch_ready    = $urandom_range(0, 1) == 1;
            step();
            for (int i = 0; i < 2; i++) begin
                checks++;
                if (fpc[i] !== m_pc[i][31:0] || fv[i] !== (m_mode[i] == M_RUN) ||
                    hl[i] !== (m_mode[i] == M_HALT) || me[i] !== m_err[i]) begin
                    errors++;
                    $display("FAIL random[%0d][%0d]: pc=%h fv=%b hl=%b me=%b, required pc=%h fv=%b hl=%b me=%b",
                             n, i, fpc[i], fv[i], hl[i], me[i], m_pc[i][31:0],
                             m_mode[i] == M_RUN, m_mode[i] == M_HALT, m_err[i]);
                end
            end
        end
        restart        = 1'b0;
        redirect_valid = 1'b0;
    endtask

    task automatic test_async_reset();
        do_restart();
        fetch_ready    = 1'b1;
        step();
        fetch_ready = 1'b0;
        step();
        #3 rst_n = 1'b0;
        #1;
        for (int i = 0; i < 2; i++) begin
            checks++;
            if (fpc[i] !== 32'h0 || fv[i] !== 1'b0 || hl[i] !== 1'b0) begin
                errors++;
                $display("FAIL async_reset_stall[%0d]: pc=%h fv=%b hl=%b, required pc=0 fv=0 hl=0",
                         i, fpc[i], fv[i], hl[i]);
            end
        end
        model_reset();
        @(posedge clk);
        #1 rst_n = 1'b1;
        step();
        redirect_valid = 1'b1;
        redirect_pc    = 32'h30;
        step();
        redirect_valid = 1'b0;
        #3 rst_n = 1'b0;
        #1;
        checks++;
        if (hl[0] !== 1'b0 || fpc[0] !== 32'h0 || fv[0] !== 1'b0) begin
            errors++;
            $display("FAIL async_reset_halt: hl=%b pc=%h fv=%b, required hl=0 pc=0 fv=0", hl[0], fpc[0], fv[0]);
        end
        model_reset();
        @(posedge clk);
        #1 rst_n = 1'b1;
        step();
        checks++;
        if (fv[0] !== 1'b1 || fpc[0] !== 32'h0) begin
            errors++;
            $display("FAIL async_reset_recover: fv=%b pc=%h, required fv=1 pc=0", fv[0], fpc[0]);
        end
    endtask

    initial begin
        rst_n          = 1'b0;
        restart        = 1'b0;
        redirect_valid = 1'b0;
        redirect_pc    = 32'h0;
        fetch_ready    = 1'b0;
        lim[0]         = 64'h24;
        lim[1]         = 64'hFFFF_FFFF;
        model_reset();

        test_reset();
        test_stream();
        test_stall();
        test_redirect_stall();
        test_limit_redirect();
        test_wrap();
        test_misalign();
        test_random();
        test_async_reset();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
